// File: rtl/byte_enabled_sdp_ram.sv
// Byte-enabled semi-dual-port RAM: one byte-masked write port and one
// combinational read port sharing a single address. Storage is split into
// NUM_LANES independent byte-wide arrays, one per write-enable bit. An X on
// one lane's enable therefore cannot touch any other lane's storage.

// One byte lane: a DEPTH x VEC_W array with its own write enable.
module byte_lane_ram #(
  parameter int ADDR_W = 16,
  parameter int VEC_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] address,
  input  logic [VEC_W-1:0]  wdata,
  output logic [VEC_W-1:0]  rdata
);
  localparam int DEPTH = 2 ** ADDR_W;

  // Power-up contents are zero, so cache tags start out invalid.
  logic [VEC_W-1:0] mem [DEPTH] = '{default: '0};

  // Write on the clock edge only while reset is low. Reset never clears the
  // array, and a write whose edge lands during reset is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (!rst && we) mem[address] <= wdata;
  end

  // Zero-latency read. The cache resolves hit/miss in the same cycle.
  assign rdata = mem[address];
endmodule

// Top level: NUM_LANES byte lanes side by side form a 32-bit word.
module byte_enabled_sdp_ram #(
  parameter int ADDRESS_BITWIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [3:0]                  write_enable,
  input  logic [ADDRESS_BITWIDTH-1:0] address,
  input  logic [31:0]                 data_in,
  output logic [31:0]                 data_out
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  logic [NUM_LANES-1:0][VEC_W-1:0] wdata;
  logic [NUM_LANES-1:0][VEC_W-1:0] rdata;

  assign wdata = data_in;

  // A zero-width address has no meaningful depth. Reject it at elaboration.
  if (ADDRESS_BITWIDTH < 1) begin : g_bad_aw
    $error("byte_enabled_sdp_ram: ADDRESS_BITWIDTH must be >= 1");
  end

  // Lane l owns data bits [8l+7:8l] and is written under write_enable[l].
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    byte_lane_ram #(
      .ADDR_W (ADDRESS_BITWIDTH),
      .VEC_W  (VEC_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .we      (write_enable[l]),
      .address (address),
      .wdata   (wdata[l]),
      .rdata   (rdata[l])
    );
  end

  // Reset masks the output. Release returns it to mem[address] with no delay.
  assign data_out = rst ? '0 : rdata;
endmodule

// File: tb/tb_byte_enabled_sdp_ram.sv
// Bench for byte_enabled_sdp_ram (ADDRESS_BITWIDTH = 8).
// Structure:
// - A vector table is driven first.
// - Hand-written sequences follow for combinational and async-reset corners.
// - A randomized phase runs last, checked against a behavioural model.
// Each expected value is queued when stimulus is driven, then popped and
// compared when the output is sampled.
module tb_byte_enabled_sdp_ram;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    write_enable;
  logic [AW-1:0] address;
  logic [31:0]   data_in;
  logic [31:0]   data_out;

  byte_enabled_sdp_ram #(.ADDRESS_BITWIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          r;
    logic [3:0]    we;
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [31:0]   e;   // data_out expected before the edge
    string         nm;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] exp_q[$];
  logic [31:0] model [256];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic add(input logic r, input logic [3:0] we, input logic [AW-1:0] a,
                     input logic [31:0] d, input logic [31:0] e, input string nm);
    vec_t v;
    v.r = r; v.we = we; v.a = a; v.d = d; v.e = e; v.nm = nm;
    tbl.push_back(v);
  endtask

  // Pop the oldest expected word and compare it under a byte mask.
  task automatic check(input string nm, input logic [31:0] mask);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: scoreboard empty, got %h", nm, data_out);
      return;
    end
    exp = exp_q.pop_front();
    n_cmp++;
    if ((data_out & mask) !== (exp & mask)) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (mask %h)", nm, data_out, exp, mask);
    end
  endtask

  // The bench needs only a few hundred cycles; anything longer is a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got %0d compares", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pick [7];
    logic [AW-1:0] ra;
    logic [31:0] m;
    pick = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd255};

    rst = 1'b1; write_enable = '0; address = '0; data_in = '0;

    //   rst  we     addr    data_in        expected       name
    add(1'b1, 4'h0, 8'd0,   32'h00000000, 32'h00000000, "reset_out");
    add(1'b0, 4'h0, 8'd5,   32'h00000000, 32'h00000000, "init_zero");
    add(1'b0, 4'hF, 8'd5,   32'hDEADBEEF, 32'h00000000, "old_before_edge");
    add(1'b0, 4'h0, 8'd5,   32'h00000000, 32'hDEADBEEF, "full_write");
    add(1'b0, 4'h0, 8'd6,   32'h00000000, 32'h00000000, "neighbour_zero");
    add(1'b0, 4'h4, 8'd5,   32'h11223344, 32'hDEADBEEF, "merge_pre");
    add(1'b0, 4'h0, 8'd5,   32'h00000000, 32'hDE22BEEF, "byte_merge");
    add(1'b0, 4'h0, 8'd5,   32'hFFFFFFFF, 32'hDE22BEEF, "nowrite_pre");
    add(1'b0, 4'h0, 8'd5,   32'h00000000, 32'hDE22BEEF, "nowrite");
    add(1'b1, 4'hF, 8'd5,   32'h12345678, 32'h00000000, "rst_forces_zero");
    add(1'b0, 4'h0, 8'd5,   32'h00000000, 32'hDE22BEEF, "rst_write_dropped");
    add(1'b0, 4'hF, 8'd255, 32'hA5A5A5A5, 32'h00000000, "top_pre");
    add(1'b0, 4'hF, 8'd0,   32'h5A5A5A5A, 32'h00000000, "bottom_pre");
    add(1'b0, 4'h0, 8'd255, 32'h00000000, 32'hA5A5A5A5, "top_word");
    add(1'b0, 4'h0, 8'd0,   32'h00000000, 32'h5A5A5A5A, "bottom_word");
    add(1'b0, 4'h1, 8'd255, 32'h000000FF, 32'hA5A5A5A5, "lane0_pre");
    add(1'b0, 4'h0, 8'd255, 32'h00000000, 32'hA5A5A5FF, "lane0_write");
    add(1'b0, 4'h8, 8'd0,   32'h77000000, 32'h5A5A5A5A, "lane3_pre");
    add(1'b0, 4'h0, 8'd0,   32'h00000000, 32'h775A5A5A, "lane3_write");

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].r; write_enable = tbl[i].we; address = tbl[i].a; data_in = tbl[i].d;
      exp_q.push_back(tbl[i].e);
      #1 check(tbl[i].nm, 32'hFFFFFFFF);
    end

    // Address changes inside one cycle are visible immediately.
    @(negedge clk);
    rst = 1'b0; write_enable = 4'h0; address = 8'd5;
    exp_q.push_back(32'hDE22BEEF); #1 check("comb_a5", 32'hFFFFFFFF);
    address = 8'd6;
    exp_q.push_back(32'h00000000); #1 check("comb_a6", 32'hFFFFFFFF);
    address = 8'd5;
    exp_q.push_back(32'hDE22BEEF); #1 check("comb_a5_again", 32'hFFFFFFFF);

    // Reset pulsed mid-cycle: output follows it with no clock involved.
    @(posedge clk); #2;
    rst = 1'b1;
    exp_q.push_back(32'h00000000); #1 check("async_rst_assert", 32'hFFFFFFFF);
    rst = 1'b0;
    exp_q.push_back(32'hDE22BEEF); #1 check("async_rst_release", 32'hFFFFFFFF);

    // An unknown enable on lane 2 must leave lanes 0, 1 and 3 correct.
    @(negedge clk);
    address = 8'd7; data_in = 32'hFFFFFFFF; write_enable = 4'b0x01;
    @(negedge clk);
    write_enable = 4'h0;
    exp_q.push_back(32'h000000FF); #1 check("x_enable_isolation", 32'hFF00FFFF);

    // Randomized phase against a model seeded with the known contents.
    foreach (model[i]) model[i] = 32'h0;
    model[0] = 32'h775A5A5A; model[5] = 32'hDE22BEEF; model[255] = 32'hA5A5A5FF;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 7) == 0);
      write_enable = 4'($urandom_range(0, 15));
      ra = pick[$urandom_range(0, 6)];
      address = ra;
      data_in = $urandom;
      exp_q.push_back(rst ? 32'h0 : model[ra]);
      #1 check("random", 32'hFFFFFFFF);
      // The upcoming edge sees these inputs; apply the same merge to the model.
      if (!rst) begin
        m = model[ra];
        for (int b = 0; b < 4; b++) if (write_enable[b]) m[8*b +: 8] = data_in[8*b +: 8];
        model[ra] = m;
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
